// File: rtl/instr_mem_sync_pkg.sv
// Shared RV32I core constants and types used by the instruction memory.
// Pure declarations, so there is no latency and no flow control.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IMEM_INIT,
        IMEM_RUN
    } imem_state_t;

endpackage

// File: rtl/instr_mem_sync_if.sv
// Fetch and load bus between the IF stage and the instruction memory.
// Fetch results arrive 1 cycle after the request; stall_i holds them and flush_i kills them.
interface instr_mem_sync_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_i;
    logic [ADDR_W-1:0] addr_i;
    logic              stall_i;
    logic              flush_i;
    logic [DATA_W-1:0] instr_o;
    logic              valid_o;
    logic              fault_o;
    logic              ready_o;
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;

    modport master (
        output req_i, addr_i, stall_i, flush_i, wr_en_i, wr_addr_i, wr_data_i,
        input  instr_o, valid_o, fault_o, ready_o
    );

    modport slave (
        input  req_i, addr_i, stall_i, flush_i, wr_en_i, wr_addr_i, wr_data_i,
        output instr_o, valid_o, fault_o, ready_o
    );
endinterface

// File: rtl/instr_mem_sync_ram.sv
// DEPTH x DATA_W storage with one registered read port and one write port, read-before-write.
// The read takes 1 cycle, and rd_data holds whenever rd_en is low.
module imem_ram_1r1w #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end
endmodule

// File: rtl/instr_mem_sync.sv
// Instruction memory: a NOP init sweep after reset, then 1-cycle fetch with flush > stall > req.
// Stall freezes all fetch outputs. The load port keeps writing during stall.
module instr_mem_sync #(
    parameter int                DEPTH     = 64,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(riscv_pkg::NOP_INSTR)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    instr_mem_sync_if.slave    bus
);
    import riscv_pkg::*;

    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * 4);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(DEPTH - 1);

    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && (a < LIMIT);
    endfunction

    imem_state_t       state;
    logic [IDX_W-1:0]  sweep_cnt;
    logic              ready_q;
    logic              valid_q;
    logic              fault_q;
    logic              from_ram_q;

    logic              fetch_ok;
    logic              fetch_fault;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_wr_idx;
    logic [DATA_W-1:0] ram_wr_data;
    logic [DATA_W-1:0] ram_rd_data;

    always_comb begin
        fetch_ok    = 1'b0;
        fetch_fault = 1'b0;
        if (state == IMEM_RUN && !bus.flush_i && !bus.stall_i && bus.req_i) begin
            fetch_ok    = addr_legal(bus.addr_i);
            fetch_fault = !addr_legal(bus.addr_i);
        end
    end

    // The sweep owns the write port until RUN. After that the load port drives it.
    always_comb begin
        ram_we      = 1'b0;
        ram_wr_idx  = bus.wr_addr_i[IDX_W+1:2];
        ram_wr_data = bus.wr_data_i;
        if (state == IMEM_INIT) begin
            ram_we      = 1'b1;
            ram_wr_idx  = sweep_cnt;
            ram_wr_data = NOP_INSTR;
        end else if (bus.wr_en_i && addr_legal(bus.wr_addr_i)) begin
            ram_we = 1'b1;
        end
    end

    imem_ram_1r1w #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we      (ram_we),
        .wr_idx  (ram_wr_idx),
        .wr_data (ram_wr_data),
        .rd_en   (fetch_ok),
        .rd_idx  (bus.addr_i[IDX_W+1:2]),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IMEM_INIT;
            sweep_cnt  <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            from_ram_q <= 1'b0;
        end else begin
            case (state)
                IMEM_INIT: begin
                    sweep_cnt  <= sweep_cnt + 1'b1;
                    valid_q    <= 1'b0;
                    fault_q    <= 1'b0;
                    from_ram_q <= 1'b0;
                    if (sweep_cnt == LAST) begin
                        state   <= IMEM_RUN;
                        ready_q <= 1'b1;
                    end
                end
                IMEM_RUN: begin
                    if (bus.flush_i) begin
                        valid_q    <= 1'b0;
                        fault_q    <= 1'b0;
                        from_ram_q <= 1'b0;
                    end else if (!bus.stall_i) begin
                        valid_q    <= bus.req_i;
                        fault_q    <= fetch_fault;
                        from_ram_q <= fetch_ok;
                    end
                end
                default: state <= IMEM_INIT;
            endcase
        end
    end

    // from_ram_q gates the RAM data, so reset and bubbles show NOP without resetting the RAM.
    assign bus.instr_o = from_ram_q ? ram_rd_data : NOP_INSTR;
    assign bus.valid_o = valid_q;
    assign bus.fault_o = fault_q;
    assign bus.ready_o = ready_q;
endmodule

// File: doc/instr_mem_sync.md
# instr_mem_sync

Parametrised, synchronous instruction memory for the pipelined RV32I core, sitting between the IF-stage PC register and the IF/ID pipeline register. It has a registered read port with valid/stall/flush control, a runtime load port for writing the program, and an init sweep that fills every word with NOP after reset. Misaligned and out-of-range fetches return NOP and raise a fault flag.

## Interface
- `DEPTH`, 64, number of 32-bit words; power of two, ≥2
- `DATA_W`, 32, instruction width
- `ADDR_W`, 32, byte-address width of fetch and load addresses
- `NOP_INSTR`, 32'h00000013, fill and bubble value (`addi x0,x0,0`)
- Derived: `IDX_W = $clog2(DEPTH)`; word index is `addr[IDX_W+1:2]`
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-low
- `req_i`  in  1  fetch request
- `addr_i`  in  ADDR_W  fetch byte address (PC)
- `stall_i`  in  1  hold all fetch outputs
- `flush_i`  in  1  kill the fetch in flight
- `instr_o`  out  DATA_W  fetched instruction
- `valid_o`  out  1  `instr_o` is a real fetch result
- `fault_o`  out  1  fetch was misaligned or out of range
- `ready_o`  out  1  init sweep complete; memory usable
- `wr_en_i`  in  1  load-port write strobe
- `wr_addr_i`  in  ADDR_W  load-port byte address
- `wr_data_i`  in  DATA_W  load-port data

## Operation
- FSM states: INIT and RUN. Reset forces INIT with sweep counter = 0.
- INIT: each cycle, write `NOP_INSTR` to word[counter], then counter++. The write of word DEPTH-1 moves the FSM to RUN. INIT takes exactly DEPTH cycles. `req_i` and `wr_en_i` are ignored in INIT.
- RUN, fetch. Priority is flush > stall > req.
  - flush_i=1: next `valid_o=0`, `instr_o=NOP_INSTR`, `fault_o=0`.
  - stall_i=1: all three fetch outputs hold their values.
  - req_i=1, address legal: next `instr_o=mem[idx]`, `valid_o=1`, `fault_o=0`.
  - req_i=1, `addr_i[1:0]≠0` or `addr_i ≥ DEPTH*4`: next `instr_o=NOP_INSTR`, `valid_o=1`, `fault_o=1`.
  - req_i=0: next `valid_o=0`, `instr_o=NOP_INSTR`, `fault_o=0`.
- RUN, load: when `wr_en_i=1` the word at the `wr_addr_i` index is written at the clock edge. Misaligned or out-of-range writes are silently dropped. Writes are accepted even while `stall_i=1`.
- Same-cycle fetch and write to the same word: the fetch returns the old data (read-before-write). The new data is visible to the next fetch.
- `ready_o` is a registered copy of the state: it is 1 in RUN only.

## Timing
- Reset values: `instr_o=NOP_INSTR`, `valid_o=0`, `fault_o=0`, `ready_o=0`, state=INIT, counter=0.
- `ready_o` rises on the edge that completes the DEPTH-th init write, i.e. DEPTH cycles after reset release.
- Fetch latency is 1 cycle: `addr_i` sampled at edge N appears on `instr_o` after edge N.
- A stall holds the outputs for every cycle it is asserted. The first edge with stall_i=0 samples the new request.
- Reset asserted mid-INIT or mid-RUN: outputs return to their reset values immediately (asynchronously), and the sweep restarts from word 0 after release. Memory contents are not otherwise preserved in a defined way.
- The fault check is combinational on `addr_i` and its result is registered with the data, so it needs no extra latency.

## Structure
- Shared package `riscv_pkg` holds:
  - `NOP_INSTR` constant
  - `imem_state_t` enum (`IMEM_INIT`, `IMEM_RUN`)
  - `XLEN=32`
- Sub-module `imem_ram_1r1w` holds the storage array: DEPTH×DATA_W, one synchronous read port, one synchronous write port, read-before-write.
- The top level holds:
  - FSM and sweep counter
  - write mux selecting the sweep or the load port
  - address legality checks
  - output registers with flush/stall priority

## Test plan
- Reset release with DEPTH=64: `ready_o` is 0 for 64 cycles, then 1. Fetches of 0x00 and 0xFC then return 0x00000013 with valid=1 and fault=0.
- Load 0x0032A383 at 0x00 and 0x00338433 at 0x04, then fetch 0x00 and 0x04 back-to-back: the two words appear on consecutive cycles, each one cycle after its request.
- Fetch 0x02, then fetch 0x100 (DEPTH=64): both return NOP with valid=1 and fault=1. A write to 0x100 changes no word.
- Fetch 0x04, then hold stall_i=1 for 3 cycles while `addr_i` changes: `instr_o` stays 0x00338433 with valid=1. Assert flush_i and stall_i together: the next cycle shows valid=0 and NOP.
- In the same cycle, write 0x402381B3 to 0x0C and fetch 0x0C: the fetch returns the old NOP. The next fetch of 0x0C returns 0x402381B3.
- Assert reset at cycle 20 of INIT: outputs take their reset values immediately. After release, `ready_o` rises only after a full 64 further cycles.
